flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits; SHALL be >= 2.
REQ-002 Port: Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: InValid  input  1  operation request this cycle.
REQ-005 Port: Op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-006 Port: S  input  1  update flag register with this operation's flags.
REQ-007 Port: Chain  input  1  multi-word mode: Z accumulates across words.
REQ-008 Port: In1, In2  input  WIDTH  operands.
REQ-009 Port: FlagWr, FlagIn  input  1, 4  direct flag register load (context restore).
REQ-010 Port: Cond  input  4  condition code to evaluate.
REQ-011 Port: OutValid  output  1  Result valid.
REQ-012 Port: Result  output  WIDTH  registered arithmetic result.
REQ-013 Port: Flags  output  4  registered {N,Z,C,V}.
REQ-014 Port: CondPass  output  1  Cond evaluated against current Flags.

Function
REQ-015 Accepted op (InValid=1) SHALL produce Result and OutValid=1 exactly one cycle later; OutValid=0 in every other cycle.
REQ-016 Arithmetic at WIDTH+1 bits: ADD In1+In2; SUB In1-In2; ADC In1+In2+C; SBC In1-In2-C; C is the registered Flags[1] at issue.
REQ-017 C SHALL be bit WIDTH of the extended result: carry-out for ADD/ADC, borrow for SUB/SBC (1 = borrow).
REQ-018 N SHALL be Result[WIDTH-1].
REQ-019 V SHALL be signed overflow: add-type when operand signs equal and result sign differs; subtract-type when operand signs differ and result sign differs from In1.
REQ-020 Z SHALL be (Result==0) when Chain=0, and (Result==0) AND registered Z when Chain=1.
REQ-021 Flags SHALL update only when InValid=1 and S=1; otherwise hold. Result SHALL update whenever InValid=1.
REQ-022 FlagWr=1 SHALL load FlagIn into Flags next cycle, with priority over an S update in the same cycle; Result/OutValid unaffected.
REQ-023 Back-to-back ops: the C and Z used by ADC/SBC/Chain SHALL be those written by the immediately preceding cycle.
REQ-024 CondPass (combinational): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI !C&!Z; 9 LS C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-025 No internal FSM beyond the output pipeline stage; InValid in every cycle SHALL be sustained at full throughput.

Reset
REQ-026 Reset=1 SHALL clear Result, Flags and OutValid to 0 next edge, overriding InValid, S and FlagWr.
REQ-027 An op issued the cycle Reset is asserted SHALL be discarded (OutValid=0 next cycle).
REQ-028 After reset, CondPass SHALL reflect Flags=0000 (EQ=0, NE=1, AL=1).

Verification (WIDTH=32)
REQ-029 SUB 5-7, S=1 -> next cycle Result=0xFFFFFFFE, Flags=1010, OutValid=1, Cond=B -> CondPass=1.
REQ-030 ADD 0x7FFFFFFF+1, S=1 -> Result=0x80000000, Flags=1001; then ADD 0xFFFFFFFF+1, S=1 -> Result=0, Flags=0110; next-cycle ADC 0+0 -> Result=1.
REQ-031 64-bit compare: SUB lo 0x0-0x0 Chain=0, then SBC hi 0x1-0x1 Chain=1 -> Flags Z=1 C=0; repeat with lo 0x1-0x0 -> Z=0.
REQ-032 Same cycle: InValid=1 SUB 3-3 S=1 and FlagWr=1 FlagIn=1001 -> Flags=1001, Result=0.
REQ-033 Issue ADD 1+1 S=1 with Reset=1 same cycle -> OutValid=0, Result=0, Flags=0000; S=0 ops leave Flags unchanged.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: registered add/sub ALU with an NZCV flag register and condition-code evaluation
module flag_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    input  logic [1:0]       Op,
    input  logic             S,
    input  logic             Chain,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             FlagWr,
    input  logic [3:0]       FlagIn,
    input  logic [3:0]       Cond,
    output logic             OutValid,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             CondPass
);
    logic [WIDTH-1:0] result_q, result_d, res;
    logic [WIDTH:0]   ext;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, valid_d, cin, n, z, c, v;

    // arithmetic in WIDTH+1 bits; Op[0] selects subtract, Op[1] pulls in the stored carry/borrow
    always_comb begin
        cin = Op[1] & flags_q[1];
        ext = Op[0] ? {1'b0, In1} - {1'b0, In2} - {{WIDTH{1'b0}}, cin}
                    : {1'b0, In1} + {1'b0, In2} + {{WIDTH{1'b0}}, cin};
        res = ext[WIDTH-1:0];
        n = res[WIDTH-1];
        z = (res == '0) & (~Chain | flags_q[2]);
        c = ext[WIDTH];
        v = Op[0] ? (In1[WIDTH-1] != In2[WIDTH-1]) & (n != In1[WIDTH-1])
                  : (In1[WIDTH-1] == In2[WIDTH-1]) & (n != In1[WIDTH-1]);
        flags_d = FlagWr ? FlagIn : (InValid & S) ? {n, z, c, v} : flags_q;
        result_d = InValid ? res : result_q;
        valid_d = InValid;
    end

    // single output stage; reset wins over every update source
    always_ff @(posedge Clk) begin
        if (Reset) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    // condition code checked against the registered {N,Z,C,V}
    always_comb begin
        CondPass = 1'b0;
        case (Cond)
            4'h0: CondPass = flags_q[2];
            4'h1: CondPass = ~flags_q[2];
            4'h2: CondPass = flags_q[1];
            4'h3: CondPass = ~flags_q[1];
            4'h4: CondPass = flags_q[3];
            4'h5: CondPass = ~flags_q[3];
            4'h6: CondPass = flags_q[0];
            4'h7: CondPass = ~flags_q[0];
            4'h8: CondPass = ~flags_q[1] & ~flags_q[2];
            4'h9: CondPass = flags_q[1] | flags_q[2];
            4'hA: CondPass = flags_q[3] == flags_q[0];
            4'hB: CondPass = flags_q[3] != flags_q[0];
            4'hC: CondPass = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: CondPass = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: CondPass = 1'b1;
            default: CondPass = 1'b0;
        endcase
    end

    assign OutValid = valid_q;
    assign Result   = result_q;
    assign Flags    = flags_q;
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: scoreboard bench for flag_unit with a signed/unsigned integer reference model
module tb_flag_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic        S = 1'b0;
    logic        Chain = 1'b0;
    logic [31:0] In1 = '0;
    logic [31:0] In2 = '0;
    logic        FlagWr = 1'b0;
    logic [3:0]  FlagIn = '0;
    logic [3:0]  Cond = '0;
    logic        OutValid;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        CondPass;

    flag_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .Op(Op), .S(S), .Chain(Chain),
        .In1(In1), .In2(In2), .FlagWr(FlagWr), .FlagIn(FlagIn), .Cond(Cond),
        .OutValid(OutValid), .Result(Result), .Flags(Flags), .CondPass(CondPass)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit        v;
        bit [31:0] r;
        bit [3:0]  f;
        bit        cp;
    } exp_t;

    exp_t      q[$];
    int        checks = 0;
    int        errors = 0;
    bit [31:0] mr = '0;
    bit [3:0]  mf = '0;

    function automatic bit cond_ok(bit [3:0] cd, bit [3:0] f);
        bit fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cd)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return !fc && !fz;
            4'h9: return fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rst, bit iv, bit [1:0] op, bit s, bit ch,
                         bit [31:0] a, bit [31:0] b, bit fw, bit [3:0] fi, bit [3:0] cd);
        exp_t   e;
        longint ua, ub, sa, sb, cin, u, sv;
        bit     n, z, c, v;
        bit [3:0] nf;
        @(negedge Clk);
        #1;
        Reset = rst; InValid = iv; Op = op; S = s; Chain = ch;
        In1 = a; In2 = b; FlagWr = fw; FlagIn = fi; Cond = cd;
        if (rst) begin
            mr = '0;
            mf = '0;
            e.v = 1'b0;
        end else begin
            nf = mf;
            if (iv) begin
                ua = longint'(a);
                ub = longint'(b);
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                cin = op[1] ? longint'(mf[1]) : 0;
                if (op[0]) begin
                    u  = ua - ub - cin;
                    sv = sa - sb - cin;
                    c  = u < 0;
                end else begin
                    u  = ua + ub + cin;
                    sv = sa + sb + cin;
                    c  = u >= 64'sd4294967296;
                end
                mr = u[31:0];
                n = mr[31];
                z = (mr == 0) && (!ch || mf[2]);
                v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
                if (s) nf = {n, z, c, v};
            end
            if (fw) nf = fi;
            mf = nf;
            e.v = iv;
        end
        e.r = mr;
        e.f = mf;
        e.cp = cond_ok(cd, mf);
        q.push_back(e);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 32'(OutValid), 32'(e.v));
            chk("result", Result, e.r);
            chk("flags", 32'(Flags), 32'(e.f));
            chk("cond_pass", 32'(CondPass), 32'(e.cp));
        end else if (OutValid === 1'b1) begin
            chk("unexpected_valid", 32'(OutValid), 32'd0);
        end
    end

    function automatic bit [31:0] pick();
        bit [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        return ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : 32'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, then condition codes on cleared flags
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
        // SUB 5-7 then LT
        drive(0, 1, 2'b01, 1, 0, 32'd5, 32'd7, 0, 0, 4'hB);
        // overflow and carry-out, then ADC consuming the carry
        drive(0, 1, 2'b00, 1, 0, 32'h7FFF_FFFF, 32'h1, 0, 0, 4'h6);
        drive(0, 1, 2'b00, 1, 0, 32'hFFFF_FFFF, 32'h1, 0, 0, 4'h2);
        drive(0, 1, 2'b10, 0, 0, 32'h0, 32'h0, 0, 0, 4'h9);
        // 64-bit equality via chained SUB/SBC, equal then unequal
        drive(0, 1, 2'b01, 1, 0, 32'h0, 32'h0, 0, 0, 4'h0);
        drive(0, 1, 2'b11, 1, 1, 32'h1, 32'h1, 0, 0, 4'h0);
        drive(0, 1, 2'b01, 1, 0, 32'h1, 32'h0, 0, 0, 4'h0);
        drive(0, 1, 2'b11, 1, 1, 32'h1, 32'h1, 0, 0, 4'h0);
        // direct flag load beats an S update in the same cycle
        drive(0, 1, 2'b01, 1, 0, 32'd3, 32'd3, 1, 4'b1001, 4'hA);
        drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'hD);
        // op issued together with reset is discarded
        drive(0, 1, 2'b00, 1, 0, 32'd9, 32'd9, 0, 0, 4'h4);
        drive(1, 1, 2'b00, 1, 0, 32'd1, 32'd1, 1, 4'hF, 4'h1);
        drive(0, 1, 2'b01, 0, 0, 32'd1, 32'd2, 0, 0, 4'h1);
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(40) == 0, $urandom_range(4) != 0, 2'($urandom), 1'($urandom),
                  1'($urandom), pick(), pick(), $urandom_range(10) == 0, 4'($urandom), 4'($urandom));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hE);
        @(negedge Clk);
        @(negedge Clk);
        if (q.size() != 0) chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
